// File: rtl/tl_rx_tlp_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tl_rx_tlp_deframer
// Purpose  : Receive-side TLP deframer. Takes DW-serial TLP beats from the
//            DLL, collects and decodes the 3/4-DW header, classifies the TLP
//            as Posted / Non-Posted / Completion, presents the header and then
//            the payload to the RX router (valid/ready), returns consumed flow
//            control credits to the DLL and drops malformed TLPs.
// Ports    : clk, arst             - clock, synchronous active-high reset
//            dll_tlp_*             - beat stream from the DLL (valid/ready,
//                                    sop/eop framing, one DW per beat)
//            hdr_valid/ready, hdr, hdr_type
//                                  - decoded header to the router
//            data_valid/ready, data, data_last, data_abort
//                                  - payload DWs to the router
//            fc_rel_*              - one-cycle credit release pulse
//            rx_malformed          - one-cycle pulse per malformed TLP
//            rx_ecrc               - trailing digest DW (TLP_DIGEST_EN only)
// Config   : TLP_DIGEST_EN - when defined, TLPs with TD=1 carry one trailing
//            digest DW that is consumed and latched on rx_ecrc; when
//            undefined, TD=1 marks the TLP malformed.
// Revision : 1.0 - initial release
// ============================================================================
module tl_rx_tlp_deframer #(
    parameter int DW             = 32,
    parameter int MAX_PAYLOAD_DW = 256,
    parameter int FC_HDR_WIDTH   = 8,
    parameter int FC_DATA_WIDTH  = 12
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     dll_tlp_valid,
    output logic                     dll_tlp_ready,
    input  logic                     dll_tlp_sop,
    input  logic                     dll_tlp_eop,
    input  logic [DW-1:0]            dll_tlp_data,
    output logic                     hdr_valid,
    input  logic                     hdr_ready,
    output logic [4*DW-1:0]          hdr,
    output logic [1:0]               hdr_type,
    output logic                     data_valid,
    input  logic                     data_ready,
    output logic [DW-1:0]            data,
    output logic                     data_last,
    output logic                     data_abort,
    output logic                     fc_rel_valid,
    output logic [1:0]               fc_rel_type,
    output logic [FC_HDR_WIDTH-1:0]  fc_rel_hdr,
    output logic [FC_DATA_WIDTH-1:0] fc_rel_data,
`ifdef TLP_DIGEST_EN
    output logic [DW-1:0]            rx_ecrc,
`endif
    output logic                     rx_malformed
);

    // Flow-control class encoding
    localparam logic [1:0] c_fc_p   = 2'd0;
    localparam logic [1:0] c_fc_np  = 2'd1;
    localparam logic [1:0] c_fc_cpl = 2'd2;

    // State encoding
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_hdr    = 3'd1;
    localparam logic [2:0] c_st_hout   = 3'd2;
    localparam logic [2:0] c_st_data   = 3'd3;
    localparam logic [2:0] c_st_drop   = 3'd4;
    localparam logic [2:0] c_st_digest = 3'd5;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]               r_state;
    logic [1:0]               r_hdr_idx;      // index of next header DW
    logic [4*DW-1:0]          r_hdr;
    logic                     r_hdr_valid;
    logic [1:0]               r_hdr_type;
    logic [1:0]               r_fc_type;
    logic [10:0]              r_len_dw;
    logic                     r_has_data;
    logic                     r_digest;
    logic [10:0]              r_cnt;          // payload DWs still expected
    logic                     r_rel_pending;  // credits owed once DROP ends
    logic                     r_malformed;
    logic                     r_fc_rel_valid;
    logic [1:0]               r_fc_rel_type;
    logic [FC_HDR_WIDTH-1:0]  r_fc_rel_hdr;
    logic [FC_DATA_WIDTH-1:0] r_fc_rel_data;

    // ------------------------------------------------------------------
    // Header decode (DW0 is always held in r_hdr[31:0] once captured)
    // ------------------------------------------------------------------
    logic [2:0]  w_fmt;
    logic [4:0]  w_type;
    logic [10:0] w_len_dw;
    logic        w_has_data;
    logic        w_td;
    logic        w_digest;
    logic        w_td_bad;
    logic        w_type_ok;
    logic [1:0]  w_fc_type;
    logic        w_too_long;
    logic        w_last_hdr;
    logic        w_eop_exp;
    logic        w_hdr_err;

    assign w_fmt      = r_hdr[31:29];
    assign w_type     = r_hdr[28:24];
    assign w_len_dw   = (r_hdr[9:0] == 10'd0) ? 11'd1024 : {1'b0, r_hdr[9:0]};
    assign w_has_data = w_fmt[1];
    assign w_td       = r_hdr[15];

`ifdef TLP_DIGEST_EN
    assign w_digest = w_td;
    assign w_td_bad = 1'b0;
`else
    assign w_digest = 1'b0;
    assign w_td_bad = w_td;
`endif

    always_comb begin
        w_type_ok = 1'b1;
        w_fc_type = c_fc_p;
        casez (w_type)
            5'b0000?: w_fc_type = w_has_data ? c_fc_p : c_fc_np; // MWr / MRd, MRdLk
            5'b00010: w_fc_type = c_fc_np;                       // IO
            5'b0010?: w_fc_type = c_fc_np;                       // Cfg0/1
            5'b10???: w_fc_type = c_fc_p;                        // Msg
            5'b01010: w_fc_type = c_fc_cpl;                      // Cpl / CplD
            default:  w_type_ok = 1'b0;
        endcase
    end

    // Length is a payload size only for data-carrying TLPs; for reads it is
    // the request size and is not bounded by the receive payload limit.
    assign w_too_long = w_has_data && (w_len_dw > 11'(MAX_PAYLOAD_DW));
    assign w_last_hdr = (r_hdr_idx == (w_fmt[0] ? 2'd3 : 2'd2));
    // The last header DW ends the TLP only when nothing follows it.
    assign w_eop_exp  = !w_has_data && !w_digest;
    assign w_hdr_err  = !w_type_ok || w_too_long || w_td_bad ||
                        (dll_tlp_eop != (w_last_hdr && w_eop_exp));

    // ------------------------------------------------------------------
    // Handshake and payload pass-through
    // ------------------------------------------------------------------
    logic w_ready;
    logic w_in_data;
    logic w_beat;
    logic w_cnt_one;

    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            c_st_idle, c_st_hdr, c_st_drop, c_st_digest: w_ready = 1'b1;
            c_st_data: w_ready = data_ready;
            default:   w_ready = 1'b0;
        endcase
        if (arst) begin
            w_ready = 1'b0;
        end
    end

    assign w_in_data     = (r_state == c_st_data) && !arst;
    assign w_beat        = dll_tlp_valid && w_ready;
    assign w_cnt_one     = (r_cnt == 11'd1);

    assign dll_tlp_ready = w_ready;
    assign data_valid    = w_in_data && dll_tlp_valid;
    assign data          = w_in_data ? dll_tlp_data : '0;
    assign data_last     = data_valid && (w_cnt_one || dll_tlp_eop);
    // With a digest pending, eop on the final payload DW means the digest is
    // missing, so that payload is also flagged as truncated.
    assign data_abort    = data_valid && dll_tlp_eop && (!w_cnt_one || r_digest);

    // ------------------------------------------------------------------
    // Credit release: fires once per presented TLP, on its final beat
    // (or on header acceptance when the header was the whole TLP).
    // ------------------------------------------------------------------
    logic                     w_release;
    logic [11:0]              w_len_p3;
    logic [11:0]              w_credits;

    assign w_release = (w_beat && dll_tlp_eop &&
                        ((r_state == c_st_data) || (r_state == c_st_digest) ||
                         ((r_state == c_st_drop) && r_rel_pending))) ||
                       ((r_state == c_st_hout) && hdr_ready && !r_has_data && !r_digest);
    assign w_len_p3  = {1'b0, r_len_dw} + 12'd3;
    assign w_credits = r_has_data ? (w_len_p3 >> 2) : 12'd0;

    always_ff @(posedge clk) begin
        if (arst) begin
            r_fc_rel_valid <= 1'b0;
            r_fc_rel_type  <= '0;
            r_fc_rel_hdr   <= '0;
            r_fc_rel_data  <= '0;
        end else begin
            r_fc_rel_valid <= w_release;
            r_fc_rel_type  <= w_release ? r_fc_type : 2'd0;
            r_fc_rel_hdr   <= w_release ? FC_HDR_WIDTH'(1) : '0;
            r_fc_rel_data  <= w_release ? FC_DATA_WIDTH'(w_credits) : '0;
        end
    end

    // ------------------------------------------------------------------
    // Main FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (arst) begin
            r_state       <= c_st_idle;
            r_hdr_idx     <= 2'd0;
            r_hdr         <= '0;
            r_hdr_valid   <= 1'b0;
            r_hdr_type    <= 2'd0;
            r_fc_type     <= 2'd0;
            r_len_dw      <= 11'd0;
            r_has_data    <= 1'b0;
            r_digest      <= 1'b0;
            r_cnt         <= 11'd0;
            r_rel_pending <= 1'b0;
            r_malformed   <= 1'b0;
        end else begin
            r_malformed <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_beat && dll_tlp_sop) begin
                        r_hdr     <= {{(3*DW){1'b0}}, dll_tlp_data};
                        r_hdr_idx <= 2'd1;
                        if (dll_tlp_eop) begin
                            r_malformed <= 1'b1;   // single-DW TLP
                        end else begin
                            r_state <= c_st_hdr;
                        end
                    end
                end

                c_st_hdr: begin
                    if (w_beat) begin
                        r_hdr[DW*r_hdr_idx +: DW] <= dll_tlp_data;
                        if (w_hdr_err) begin
                            r_malformed <= 1'b1;
                            r_state     <= dll_tlp_eop ? c_st_idle : c_st_drop;
                        end else if (w_last_hdr) begin
                            r_state     <= c_st_hout;
                            r_hdr_valid <= 1'b1;
                            r_hdr_type  <= w_fc_type;
                            r_fc_type   <= w_fc_type;
                            r_len_dw    <= w_len_dw;
                            r_has_data  <= w_has_data;
                            r_digest    <= w_digest;
                        end else begin
                            r_hdr_idx <= r_hdr_idx + 2'd1;
                        end
                    end
                end

                c_st_hout: begin
                    if (hdr_ready) begin
                        r_hdr_valid <= 1'b0;
                        r_cnt       <= r_len_dw;
                        if (r_has_data) begin
                            r_state <= c_st_data;
                        end else if (r_digest) begin
                            r_state <= c_st_digest;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end
                end

                c_st_data: begin
                    if (w_beat) begin
                        if (dll_tlp_eop) begin
                            r_state <= c_st_idle;
                            if (!w_cnt_one || r_digest) begin
                                r_malformed <= 1'b1;
                            end
                        end else if (w_cnt_one) begin
                            if (r_digest) begin
                                r_state <= c_st_digest;
                            end else begin
                                // Payload longer than Length: drop the rest,
                                // credits go out when the TLP finally ends.
                                r_malformed   <= 1'b1;
                                r_rel_pending <= 1'b1;
                                r_state       <= c_st_drop;
                            end
                        end else begin
                            r_cnt <= r_cnt - 11'd1;
                        end
                    end
                end

`ifdef TLP_DIGEST_EN
                c_st_digest: begin
                    if (w_beat) begin
                        if (dll_tlp_eop) begin
                            r_state <= c_st_idle;
                        end else begin
                            r_malformed   <= 1'b1;
                            r_rel_pending <= 1'b1;
                            r_state       <= c_st_drop;
                        end
                    end
                end
`endif

                c_st_drop: begin
                    if (w_beat && dll_tlp_eop) begin
                        r_state       <= c_st_idle;
                        r_rel_pending <= 1'b0;
                    end
                end

                default: r_state <= c_st_idle;
            endcase
        end
    end

`ifdef TLP_DIGEST_EN
    logic [DW-1:0] r_ecrc;

    always_ff @(posedge clk) begin
        if (arst) begin
            r_ecrc <= '0;
        end else if (w_beat && (r_state == c_st_digest)) begin
            r_ecrc <= dll_tlp_data;
        end
    end

    assign rx_ecrc = r_ecrc;
`endif

    assign hdr_valid    = r_hdr_valid;
    assign hdr          = r_hdr;
    assign hdr_type     = r_hdr_type;
    assign fc_rel_valid = r_fc_rel_valid;
    assign fc_rel_type  = r_fc_rel_type;
    assign fc_rel_hdr   = r_fc_rel_hdr;
    assign fc_rel_data  = r_fc_rel_data;
    assign rx_malformed = r_malformed;

endmodule
`default_nettype wire

// File: tb/tb_tl_rx_tlp_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_rx_tlp_deframer
// Purpose  : Directed self-checking bench for tl_rx_tlp_deframer. Drives TLP
//            beat sequences, records router-side traffic and credit pulses on
//            the falling edge, and compares against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl_rx_tlp_deframer;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          arst;
    logic          dll_tlp_valid;
    logic          dll_tlp_ready;
    logic          dll_tlp_sop;
    logic          dll_tlp_eop;
    logic [DW-1:0] dll_tlp_data;
    logic          hdr_valid;
    logic          hdr_ready;
    logic [4*DW-1:0] hdr;
    logic [1:0]    hdr_type;
    logic          data_valid;
    logic          data_ready;
    logic [DW-1:0] data;
    logic          data_last;
    logic          data_abort;
    logic          fc_rel_valid;
    logic [1:0]    fc_rel_type;
    logic [7:0]    fc_rel_hdr;
    logic [11:0]   fc_rel_data;
    logic          rx_malformed;

    always #5 clk = ~clk;

    tl_rx_tlp_deframer dut (
        .clk           (clk),
        .arst          (arst),
        .dll_tlp_valid (dll_tlp_valid),
        .dll_tlp_ready (dll_tlp_ready),
        .dll_tlp_sop   (dll_tlp_sop),
        .dll_tlp_eop   (dll_tlp_eop),
        .dll_tlp_data  (dll_tlp_data),
        .hdr_valid     (hdr_valid),
        .hdr_ready     (hdr_ready),
        .hdr           (hdr),
        .hdr_type      (hdr_type),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .data          (data),
        .data_last     (data_last),
        .data_abort    (data_abort),
        .fc_rel_valid  (fc_rel_valid),
        .fc_rel_type   (fc_rel_type),
        .fc_rel_hdr    (fc_rel_hdr),
        .fc_rel_data   (fc_rel_data),
        .rx_malformed  (rx_malformed)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Observation records
    int           cyc = 0;
    int           beat_cyc_q[$];
    logic [31:0]  data_q[$];
    logic         last_q[$];
    logic         abort_q[$];
    logic [127:0] hdr_q[$];
    logic [1:0]   htype_q[$];
    int           hcyc_q[$];
    logic [21:0]  fc_q[$];
    int           malf_cnt   = 0;
    int           dstall_cnt = 0;
    int           badrdy_cnt = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (dll_tlp_valid && dll_tlp_ready) beat_cyc_q.push_back(cyc);
        if (data_valid && data_ready) begin
            data_q.push_back(data);
            last_q.push_back(data_last);
            abort_q.push_back(data_abort);
        end
        if (data_valid && !data_ready) dstall_cnt = dstall_cnt + 1;
        if (data_valid && (dll_tlp_ready != data_ready)) badrdy_cnt = badrdy_cnt + 1;
        if (hdr_valid && hdr_ready) begin
            hdr_q.push_back(hdr);
            htype_q.push_back(hdr_type);
            hcyc_q.push_back(cyc);
        end
        if (fc_rel_valid) fc_q.push_back({fc_rel_type, fc_rel_hdr, fc_rel_data});
        if (rx_malformed) malf_cnt = malf_cnt + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        beat_cyc_q.delete();
        data_q.delete();
        last_q.delete();
        abort_q.delete();
        hdr_q.delete();
        htype_q.delete();
        hcyc_q.delete();
        fc_q.delete();
        malf_cnt   = 0;
        dstall_cnt = 0;
        badrdy_cnt = 0;
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic push(input logic s, input logic e, input logic [31:0] d);
        int waits;
        waits         = 0;
        dll_tlp_valid = 1'b1;
        dll_tlp_sop   = s;
        dll_tlp_eop   = e;
        dll_tlp_data  = d;
        @(negedge clk);
        while (!dll_tlp_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!dll_tlp_ready) check("push_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        dll_tlp_valid = 1'b0;
        dll_tlp_sop   = 1'b0;
        dll_tlp_eop   = 1'b0;
    endtask

    // Beat 0 is dw0 (sop); beat i>0 carries base+i.
    task automatic send_tlp(input int n, input logic [31:0] dw0, input logic [31:0] base,
                            input bit with_eop);
        for (int i = 0; i < n; i++) begin
            push(i == 0, with_eop && (i == n - 1), (i == 0) ? dw0 : base + 32'(i));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        arst          = 1'b1;
        dll_tlp_valid = 1'b0;
        dll_tlp_sop   = 1'b0;
        dll_tlp_eop   = 1'b0;
        dll_tlp_data  = '0;
        hdr_ready     = 1'b1;
        data_ready    = 1'b1;

        // ---------------- reset state ----------------
        idle(3);
        check("rst_hdr_valid", hdr_valid, 1'b0);
        check("rst_hdr", hdr, 128'd0);
        check("rst_fc_rel_valid", fc_rel_valid, 1'b0);
        check("rst_malformed", rx_malformed, 1'b0);
        check("rst_ready", dll_tlp_ready, 1'b0);
        arst = 1'b0;
        @(negedge clk);
        check("idle_ready", dll_tlp_ready, 1'b1);
        idle(1);

        // ---------------- 1: MWr 3DW len=4 ----------------
        clr();
        send_tlp(7, 32'h4000_0004, 32'h1100_0000, 1'b1);
        idle(4);
        check("t1_hdr_cnt", hdr_q.size(), 1);
        check("t1_hdr", hdr_q[0], {32'h0, 32'h1100_0002, 32'h1100_0001, 32'h4000_0004});
        check("t1_hdr_type", htype_q[0], 2'd0);
        check("t1_hdr_latency", hcyc_q[0] - beat_cyc_q[2], 1);
        check("t1_data_cnt", data_q.size(), 4);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("t1_data%0d", j), data_q[j], 32'h1100_0003 + 32'(j));
            check($sformatf("t1_last%0d", j), last_q[j], (j == 3));
            check($sformatf("t1_abort%0d", j), abort_q[j], 1'b0);
        end
        check("t1_fc_cnt", fc_q.size(), 1);
        check("t1_fc", fc_q[0], {2'd0, 8'd1, 12'd1});
        check("t1_malformed", malf_cnt, 0);

        // ---------------- 2+3: MRd 4DW len=16, then CplD len=6 with stall ----------------
        clr();
        fork
            begin
                send_tlp(4, 32'h2000_0010, 32'h2200_0000, 1'b1);
                send_tlp(9, 32'h4A00_0006, 32'h3300_0000, 1'b1);
            end
            begin
                int k;
                k = 0;
                while (data_q.size() < 2 && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                @(posedge clk);
                #1 data_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 data_ready = 1'b1;
            end
        join
        idle(4);
        check("t2_hdr_cnt", hdr_q.size(), 2);
        check("t2_hdr_type", htype_q[0], 2'd1);
        check("t2_hdr_dw3", hdr_q[0][127:96], 32'h2200_0003);
        check("t2_next_sop_gap", beat_cyc_q[4] - beat_cyc_q[3], 2);
        check("t3_hdr_type", htype_q[1], 2'd2);
        check("t3_data_cnt", data_q.size(), 6);
        for (int j = 0; j < 6; j++) begin
            check($sformatf("t3_data%0d", j), data_q[j], 32'h3300_0003 + 32'(j));
            check($sformatf("t3_last%0d", j), last_q[j], (j == 5));
        end
        check("t3_stall_cycles", dstall_cnt, 3);
        check("t3_ready_follow", badrdy_cnt, 0);
        check("t23_fc_cnt", fc_q.size(), 2);
        check("t2_fc", fc_q[0], {2'd1, 8'd1, 12'd0});
        check("t3_fc", fc_q[1], {2'd2, 8'd1, 12'd2});
        check("t23_malformed", malf_cnt, 0);

        // ---------------- 4: MWr len=8, eop on 5th payload DW ----------------
        clr();
        send_tlp(8, 32'h4000_0008, 32'h4400_0000, 1'b1);
        idle(4);
        check("t4_data_cnt", data_q.size(), 5);
        check("t4_last3", last_q[3], 1'b0);
        check("t4_last4", last_q[4], 1'b1);
        check("t4_abort4", abort_q[4], 1'b1);
        check("t4_data4", data_q[4], 32'h4400_0007);
        check("t4_malformed", malf_cnt, 1);
        check("t4_fc_cnt", fc_q.size(), 1);
        check("t4_fc", fc_q[0], {2'd0, 8'd1, 12'd2});

        // ---------------- 5: Type=11111, 6 beats ----------------
        clr();
        send_tlp(6, 32'h1F00_0001, 32'h5500_0000, 1'b1);
        idle(4);
        check("t5_malformed", malf_cnt, 1);
        check("t5_hdr_cnt", hdr_q.size(), 0);
        check("t5_data_cnt", data_q.size(), 0);
        check("t5_fc_cnt", fc_q.size(), 0);
        check("t5_no_stall", beat_cyc_q[5] - beat_cyc_q[0], 5);

        // ---------------- 6: reset during DATA of len=32 ----------------
        clr();
        send_tlp(8, 32'h4000_0020, 32'h6600_0000, 1'b0);
        dll_tlp_valid = 1'b1;
        dll_tlp_data  = 32'h6600_0008;
        arst          = 1'b1;
        idle(1);
        check("t6_hdr_valid", hdr_valid, 1'b0);
        check("t6_data_valid", data_valid, 1'b0);
        check("t6_data_last", data_last, 1'b0);
        check("t6_fc_rel_valid", fc_rel_valid, 1'b0);
        check("t6_malformed_out", rx_malformed, 1'b0);
        check("t6_ready", dll_tlp_ready, 1'b0);
        dll_tlp_valid = 1'b0;
        arst          = 1'b0;
        idle(4);
        check("t6_fc_cnt", fc_q.size(), 0);
        check("t6_malformed", malf_cnt, 0);
        clr();
        send_tlp(7, 32'h4000_0004, 32'h6700_0000, 1'b1);
        idle(4);
        check("t6b_hdr_cnt", hdr_q.size(), 1);
        check("t6b_data_cnt", data_q.size(), 4);
        check("t6b_data3", data_q[3], 32'h6700_0006);
        check("t6b_fc", fc_q[0], {2'd0, 8'd1, 12'd1});

        // ---------------- 7: MWr with length above the payload limit ----------------
        clr();
        send_tlp(3, 32'h4000_0101, 32'h7700_0000, 1'b1);
        idle(4);
        check("t7_malformed", malf_cnt, 1);
        check("t7_hdr_cnt", hdr_q.size(), 0);
        check("t7_fc_cnt", fc_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
